// File: rtl/hyst_comp_real.sv
// Registered fixed-point comparator with hysteresis/window modes, persistence filter and edge pulses.
// Optional transition counter on `cnt` when HYST_COMP_REAL_CNT_EN is defined.
module hyst_comp_real #(
    parameter int width_a     = 16,
    parameter int exponent_a  = -8,
    parameter int width_hi    = 16,
    parameter int exponent_hi = -8,
    parameter int width_lo    = 16,
    parameter int exponent_lo = -8,
    parameter int mode        = 0,
    parameter int persist     = 1,
    parameter bit init        = 1'b0,
    parameter int cnt_width   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cke,
    input  logic signed [width_a-1:0]  a,
    input  logic signed [width_hi-1:0] hi,
    input  logic signed [width_lo-1:0] lo,
    output logic                       c,
    output logic                       rise,
    output logic                       fall
`ifdef HYST_COMP_REAL_CNT_EN
    ,
    output logic [cnt_width-1:0]       cnt
`endif
);

    function automatic int min3(input int x, input int y, input int z);
        int m;
        m = (x < y) ? x : y;
        return (m < z) ? m : z;
    endfunction

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

    // Common format: finest LSB of the three operands, wide enough that no operand loses range.
    localparam int exp_min = min3(exponent_a, exponent_hi, exponent_lo);
    localparam int sh_a    = exponent_a  - exp_min;
    localparam int sh_hi   = exponent_hi - exp_min;
    localparam int sh_lo   = exponent_lo - exp_min;
    localparam int w_al    = max3(width_a + sh_a, width_hi + sh_hi, width_lo + sh_lo);

    localparam logic [7:0] run_last = 8'(persist - 1);

    if (mode != 0 && mode != 1) begin : g_bad_mode
        $error("hyst_comp_real: mode must be 0 or 1");
    end
    if (persist < 1 || persist > 255) begin : g_bad_persist
        $error("hyst_comp_real: persist must be in 1..255");
    end
    if (cnt_width < 1) begin : g_bad_cnt_width
        $error("hyst_comp_real: cnt_width must be at least 1");
    end

    logic signed [w_al-1:0] a_al;
    logic signed [w_al-1:0] hi_al;
    logic signed [w_al-1:0] lo_al;

    assign a_al  = w_al'(a)  <<< sh_a;
    assign hi_al = w_al'(hi) <<< sh_hi;
    assign lo_al = w_al'(lo) <<< sh_lo;

    logic       set_hit;
    logic       clr_hit;
    logic       t;
    logic [7:0] run;
    logic       flip;

    always_comb begin
        set_hit = (a_al >= hi_al);
        clr_hit = (a_al <= lo_al);
        t       = c;
        if (mode == 1) begin
            t = (a_al >= lo_al) && (a_al <= hi_al);
        end else if (set_hit && !clr_hit) begin
            t = 1'b1;
        end else if (clr_hit && !set_hit) begin
            t = 1'b0;
        end
    end

    assign flip = cke && (t != c) && (run == run_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c    <= init;
            run  <= 8'd0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            // NOTE: pulses default low every edge so they last exactly one cycle and stay 0 while cke=0.
            rise <= 1'b0;
            fall <= 1'b0;
            if (cke) begin
                if (t == c) begin
                    run <= 8'd0;
                end else if (run == run_last) begin
                    c    <= t;
                    run  <= 8'd0;
                    rise <= t;
                    fall <= !t;
                end else begin
                    run <= run + 8'd1;
                end
            end
        end
    end

`ifdef HYST_COMP_REAL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flip && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_flip;
    assign unused_flip = flip;
`endif

endmodule

// File: tb/tb_hyst_comp_real.sv
// Bench for hyst_comp_real: five configurations share one stimulus stream, checked every cycle
// against a real-valued model plus directed literal expectations.
module tb_hyst_comp_real;

    localparam int N = 5;
    localparam int P_MODE[N]    = '{0, 0, 1, 0, 0};
    localparam int P_PERSIST[N] = '{1, 4, 1, 2, 8};
    localparam int P_INIT[N]    = '{0, 0, 0, 0, 1};
    localparam int CNT_MAX      = 3;

    typedef struct {
        bit c;
        int streak;
        bit rise;
        bit fall;
        int cnt;
    } mstate_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cke = 1'b0;
    logic signed [15:0] a_raw  = '0;
    logic signed [11:0] hi_raw = '0;
    logic signed [11:0] lo_raw = '0;
    real a_v  = 0.0;
    real hi_v = 0.0;
    real lo_v = 0.0;

    logic [N-1:0] dc;
    logic [N-1:0] dr;
    logic [N-1:0] df;
    logic [1:0]   dcnt [N];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;
    int rise_seen;
    int fall_seen;

    mstate_t m [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hyst_comp_real #(
            .width_a(16), .exponent_a(-8),
            .width_hi(12), .exponent_hi(-4),
            .width_lo(12), .exponent_lo(-4),
            .mode(P_MODE[g]), .persist(P_PERSIST[g]),
            .init(P_INIT[g] != 0), .cnt_width(2)
        ) u_dut (
            .clk(clk), .rst(rst), .cke(cke),
            .a(a_raw), .hi(hi_raw), .lo(lo_raw),
            .c(dc[g]), .rise(dr[g]), .fall(df[g])
`ifdef HYST_COMP_REAL_CNT_EN
            , .cnt(dcnt[g])
`endif
        );
`ifndef HYST_COMP_REAL_CNT_EN
        assign dcnt[g] = 2'd0;
`endif
    end

    function automatic mstate_t reset_state(input int i);
        mstate_t s;
        s.c = (P_INIT[i] != 0);
        s.streak = 0;
        s.rise = 1'b0;
        s.fall = 1'b0;
        s.cnt = 0;
        return s;
    endfunction

    // The output follows the wanted level once it has disagreed for `persist` enabled cycles in a row.
    function automatic mstate_t step(input mstate_t s, input int md, input int pers,
                                     input real av, input real hv, input real lv, input bit en);
        mstate_t n;
        bit want;
        n = s;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (!en) return n;
        if (md == 1) want = (av >= lv) && (av <= hv);
        else if ((av >= hv) && !(av <= lv)) want = 1'b1;
        else if ((av <= lv) && !(av >= hv)) want = 1'b0;
        else want = s.c;
        if (want == s.c) begin
            n.streak = 0;
        end else begin
            n.streak = s.streak + 1;
            if (n.streak >= pers) begin
                n.c = want;
                n.streak = 0;
                n.rise = want;
                n.fall = !want;
                if (n.cnt < CNT_MAX) n.cnt = n.cnt + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) m[i] <= reset_state(i);
            else     m[i] <= step(m[i], P_MODE[i], P_PERSIST[i], a_v, hi_v, lo_v, cke);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("model_c[%0d]", i), int'(dc[i]), int'(m[i].c));
                check($sformatf("model_rise[%0d]", i), int'(dr[i]), int'(m[i].rise));
                check($sformatf("model_fall[%0d]", i), int'(df[i]), int'(m[i].fall));
`ifdef HYST_COMP_REAL_CNT_EN
                check($sformatf("model_cnt[%0d]", i), int'(dcnt[i]), m[i].cnt);
`endif
            end
        end
    end

    task automatic set_th(input real hv, input real lv);
        hi_v = hv;
        lo_v = lv;
        hi_raw = 12'(int'(hv * 16.0));
        lo_raw = 12'(int'(lv * 16.0));
    endtask

    task automatic cyc(input real av, input logic en);
        a_v = av;
        a_raw = 16'(int'(av * 256.0));
        cke = en;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    real win_a[5] = '{-1.0, -0.5, 0.0, 0.5, 0.75};
    int  win_c[5] = '{0, 1, 1, 1, 0};

    initial begin
        set_th(2.0, 1.0);
        cke = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_c0", int'(dc[0]), 0);
        check("reset_c4", int'(dc[4]), 1);
        check("reset_rise", int'(dr), 0);
        check("reset_fall", int'(df), 0);
        cmp_on = 1'b1;
        rst = 1'b0;

        // Hysteresis ramp on persist=1
        rise_seen = 0;
        fall_seen = 0;
        for (int k = 0; k <= 12; k++) begin
            cyc(k * 0.25, 1'b1);
            check($sformatf("ramp_up_c k=%0d", k), int'(dc[0]), (k >= 8) ? 1 : 0);
            rise_seen += int'(dr[0]);
            fall_seen += int'(df[0]);
        end
        for (int k = 12; k >= 0; k--) begin
            cyc(k * 0.25, 1'b1);
            check($sformatf("ramp_dn_c k=%0d", k), int'(dc[0]), (k > 4) ? 1 : 0);
            rise_seen += int'(dr[0]);
            fall_seen += int'(df[0]);
        end
        check("ramp_rise_count", rise_seen, 1);
        check("ramp_fall_count", fall_seen, 1);

        // Persistence: short bursts never qualify
        for (int k = 0; k < 5; k++) cyc(0.0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(2.5, 1'b1);
                check("burst_c", int'(dc[1]), 0);
                check("burst_rise", int'(dr[1]), 0);
            end
            cyc(0.5, 1'b1);
            check("burst_c_after", int'(dc[1]), 0);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(2.5, 1'b1);
            check($sformatf("persist4_c e=%0d", k), int'(dc[1]), (k == 4) ? 1 : 0);
            check($sformatf("persist4_rise e=%0d", k), int'(dr[1]), (k == 4) ? 1 : 0);
        end
        cyc(2.5, 1'b1);
        check("persist4_rise_one_cycle", int'(dr[1]), 0);

        // Window mode, inclusive bounds, then empty window
        set_th(0.5, -0.5);
        for (int k = 0; k < 5; k++) begin
            cyc(win_a[k], 1'b1);
            check($sformatf("window_c a=%0.2f", win_a[k]), int'(dc[2]), win_c[k]);
        end
        set_th(0.0, 1.0);
        for (int k = 0; k < 3; k++) begin
            cyc(k * 0.5, 1'b1);
            check("empty_window_c", int'(dc[2]), 0);
        end

        // Clock enable gating on persist=2
        set_th(2.0, 1.0);
        for (int k = 0; k < 3; k++) cyc(0.0, 1'b1);
        cyc(3.0, 1'b1);
        check("cke_e1_c", int'(dc[3]), 0);
        cyc(3.0, 1'b0);
        check("cke_d1_c", int'(dc[3]), 0);
        check("cke_d1_rise", int'(dr[3]), 0);
        cyc(3.0, 1'b1);
        check("cke_e2_c", int'(dc[3]), 1);
        check("cke_e2_rise", int'(dr[3]), 1);
        cyc(3.0, 1'b0);
        check("cke_d2_c", int'(dc[3]), 1);
        check("cke_d2_rise", int'(dr[3]), 0);

        // Reset mid-run on persist=8, init=1
        for (int k = 0; k < 9; k++) cyc(0.0, 1'b1);
        check("pre_reset_c4", int'(dc[4]), 0);
        for (int k = 0; k < 5; k++) cyc(3.0, 1'b1);
        check("pending_run_c4", int'(dc[4]), 0);
        rst = 1'b1;
        #1;
        check("async_reset_c4", int'(dc[4]), 1);
        a_v = 0.0;
        a_raw = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(0.0, 1'b1);
            check($sformatf("post_reset_c4 e=%0d", k), int'(dc[4]), (k == 8) ? 0 : 1);
            check($sformatf("post_reset_fall4 e=%0d", k), int'(df[4]), (k == 8) ? 1 : 0);
        end

`ifdef HYST_COMP_REAL_CNT_EN
        // Transition counter saturation with cnt_width=2
        reset_pulse();
        cyc(3.0, 1'b1);
        check("cnt_t1", int'(dcnt[0]), 1);
        cyc(0.0, 1'b1);
        check("cnt_t2", int'(dcnt[0]), 2);
        cyc(3.0, 1'b1);
        check("cnt_t3", int'(dcnt[0]), 3);
        cyc(0.0, 1'b1);
        check("cnt_t4", int'(dcnt[0]), 3);
        cyc(3.0, 1'b1);
        check("cnt_t5", int'(dcnt[0]), 3);
`endif

        cmp_on = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hyst_comp_real.md
# hyst_comp_real

Registered fixed-point real comparator with hysteresis, window mode and persistence filtering. It is the sequential successor to the combinational real comparator in the svreal library. All three real operands (`a`, `hi`, `lo`) are aligned to a common format. The block produces a glitch-free state bit plus one-cycle edge pulses. It sits between analog-model signal paths and digital control logic: threshold detectors, limit monitors, crossing detectors.

## Interface
Parameters:
- `DECL_REAL(a)`, `DECL_REAL(hi)`, `DECL_REAL(lo)`: svreal format parameters (width/exponent/range) of each operand.
- `mode`, 0: 0 = hysteresis (set at/above `hi`, clear at/below `lo`); 1 = window (`c`=1 while `lo` ≤ `a` ≤ `hi`).
- `persist`, 1: consecutive enabled cycles a new target must hold before `c` changes; legal range 1..255.
- `init`, 0: reset value of `c`.
- `cnt_width`, 16: width of transition counter (only with `HYST_COMP_REAL_CNT_EN`).

Ports:
- `clk`  input  1  clock, all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `cke`  input  1  clock enable; when low all state holds.
- `a`  input  real(a)  signal under test.
- `hi`  input  real(hi)  upper threshold.
- `lo`  input  real(lo)  lower threshold.
- `c`  output  1  filtered comparator state, registered.
- `rise`  output  1  one-cycle pulse on `c` 0→1.
- `fall`  output  1  one-cycle pulse on `c` 1→0.
- `cnt`  output  cnt_width  transition count (present only with `HYST_COMP_REAL_CNT_EN`).

## Operation
- Alignment: `a`, `hi`, `lo` are converted to a common format whose range is the maximum of the three ranges, using the standard real-assign path. All compares are signed, on the aligned values.
- Target `t` per cycle:
  - mode 0: `set` = (`a` ≥ `hi`), `clr` = (`a` ≤ `lo`). `t`=1 if `set` & !`clr`; `t`=0 if `clr` & !`set`. `t`=`c` if neither or both are true (hold; covers misordered `lo` > `hi`).
  - mode 1: `t` = (`lo` ≤ `a`) & (`a` ≤ `hi`). Empty window (`lo` > `hi`) gives `t`=0.
- Persistence filter (8-bit run counter `run`), on each cycle with `cke`=1:
  - `t` == `c`: `run` ← 0.
  - `t` != `c` and `run` == `persist`-1: `c` ← `t`, `run` ← 0, assert `rise` or `fall` matching direction.
  - otherwise: `run` ← `run`+1.
- A target that reverts before reaching `persist` resets `run`. No partial credit carries over.
- `rise`/`fall` are registered and high for exactly one cycle. They are never both high.
- `cke`=0: `c`, `run`, `cnt` hold; `rise`/`fall` forced 0 that cycle.
- Illegal `mode` or `persist` outside 1..255: `$error` at elaboration.

## Timing
- Reset (async assert, sync-to-`clk` deassert by the parent): `c`=`init`, `rise`=`fall`=0, `run`=0, `cnt`=0.
- Reset asserted mid-run discards the pending run. After release, the filter restarts from `c`=`init`.
- Latency: the condition sampled true at edge k with `run`=0 updates `c` at edge k+`persist`-1 (visible after edge k+`persist`-1). For `persist`=1, `c` follows `t` one cycle after inputs change.
- Edge pulses coincide with the `c` change (same cycle).
- Inputs are sampled only at rising `clk` with `cke`=1. Cycles with `cke`=0 do not count toward `persist`.

## Configuration
- `HYST_COMP_REAL_CNT_EN` defined: `cnt` port present. It increments by 1 on every `c` change, saturates at 2^`cnt_width`-1 (no wrap), and is cleared only by `rst`.
- Not defined: `cnt` port and counter logic absent; all other behaviour identical.

## Test plan
- Mode 0, `hi`=2.0, `lo`=1.0, `persist`=1, `init`=0: ramp `a` 0.0→3.0→0.0 in 0.25 steps. Required: `c` rises one cycle after `a`=2.0, falls one cycle after `a`=1.0; a single `rise` and single `fall`; no toggling for 1.0<`a`<2.0.
- Mode 0, `persist`=4: `a`=2.5 for 3 cycles then 0.5, repeated. Required: `c` stays 0, no pulses. Then `a`=2.5 for 4 cycles: `c`=1 on the 4th edge with `rise` for one cycle.
- Mode 1, `lo`=-0.5, `hi`=0.5: `a` ∈ {-1.0, -0.5, 0.0, 0.5, 0.75}. Required: `c` = 0,1,1,1,0 (one-cycle lag, inclusive bounds). Repeat with `lo`=1.0, `hi`=0.0: `c` stays 0.
- `cke` toggling 1,0,1,0 with `persist`=2 and `a` above `hi`: `c` changes on the second enabled edge only; `rise`=0 on disabled cycles.
- Reset during run (`persist`=8, `rst` after 5 cycles above `hi`), `init`=1: `c`=1 immediately on `rst`, `run` cleared. After release with `a` below `lo`, `c`=0 after 8 enabled cycles.
- With `HYST_COMP_REAL_CNT_EN`, `cnt_width`=2: force 5 transitions. Required: `cnt` = 1,2,3,3,3 (saturation).
